// File: rtl/fsm_mon_pkg.sv
// ---------------------------------------------------------------------------
// fsm_mon_pkg
// Shared types for the FSM state monitor: the monitor's own state encoding
// and the width of its debug state output.
// ---------------------------------------------------------------------------
package fsm_mon_pkg;

  localparam int MON_W = 2;

  typedef enum logic [MON_W-1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } mon_state_e;

endpackage : fsm_mon_pkg

// File: rtl/fsm_state_monitor_if.sv
// ---------------------------------------------------------------------------
// fsm_state_monitor_if
// Groups the observation inputs and the recorded-result outputs of the
// FSM state monitor.
//   master : drives state_valid/state_in/clear, reads the results
//   slave  : the monitor itself
// Signals:
//   state_valid    sample qualifier
//   state_in       observed state encoding
//   clear          synchronous clear of all recorded information
//   visited        sticky per-encoding visit bits
//   trans_count    saturating transition count
//   illegal_pulse  one-cycle pulse on first illegal sample
//   illegal_sticky held illegal flag
//   stuck          same state held for >= STUCK_LIMIT repeats
//   all_visited    every legal encoding seen
//   mon_state      monitor FSM state (debug)
// ---------------------------------------------------------------------------
interface fsm_state_monitor_if #(
  parameter int STATE_W = 2,
  parameter int CNT_W   = 8
);
  import fsm_mon_pkg::*;

  logic                  state_valid;
  logic [STATE_W-1:0]    state_in;
  logic                  clear;
  logic [2**STATE_W-1:0] visited;
  logic [CNT_W-1:0]      trans_count;
  logic                  illegal_pulse;
  logic                  illegal_sticky;
  logic                  stuck;
  logic                  all_visited;
  logic [MON_W-1:0]      mon_state;

  modport master (
    output state_valid, state_in, clear,
    input  visited, trans_count, illegal_pulse, illegal_sticky,
           stuck, all_visited, mon_state
  );

  modport slave (
    input  state_valid, state_in, clear,
    output visited, trans_count, illegal_pulse, illegal_sticky,
           stuck, all_visited, mon_state
  );

endinterface : fsm_state_monitor_if

// File: rtl/fsm_state_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at MAX. clr has priority over inc.
// Ports:
//   clk, rst  clock, async active-high reset
//   clr       synchronous clear to zero
//   inc       increment request
//   count     current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/fsm_state_monitor.sv
// ---------------------------------------------------------------------------
// fsm_state_monitor
// Run-time observer for a small encoded FSM. Records visited encodings,
// counts state changes, flags illegal encodings and detects a machine
// that stays in one state too long.
// Ports:
//   clk  clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  fsm_state_monitor_if.slave (samples in, recorded results out)
// ---------------------------------------------------------------------------
module fsm_state_monitor
  import fsm_mon_pkg::*;
#(
  parameter int STATE_W     = 2,
  parameter int NUM_STATES  = 3,
  parameter int STUCK_LIMIT = 16,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                rst,
  fsm_state_monitor_if.slave bus
);

  localparam int SC_W = $clog2(STUCK_LIMIT + 1);

  mon_state_e            r_mon_state;
  mon_state_e            w_mon_next;
  logic [STATE_W-1:0]    r_prev_state;
  logic [2**STATE_W-1:0] r_visited;
  logic                  r_illegal_pulse;
  logic                  r_illegal_sticky;
  logic                  r_stuck;

  logic                  w_illegal;
  logic                  w_upd_prev;
  logic                  w_upd_visited;
  logic                  w_set_illegal;
  logic                  w_trans_inc;
  logic                  w_stuck_inc;
  logic                  w_stuck_clr;
  logic [CNT_W-1:0]      w_trans_cnt;
  logic [SC_W-1:0]       w_stuck_cnt;

  assign w_illegal = (32'(bus.state_in) >= 32'(NUM_STATES));

  // Next-state and per-cycle update enables. clear overrides everything,
  // so a sample arriving together with clear is discarded.
  always_comb begin
    w_mon_next    = r_mon_state;
    w_upd_prev    = 1'b0;
    w_upd_visited = 1'b0;
    w_set_illegal = 1'b0;
    w_trans_inc   = 1'b0;
    w_stuck_inc   = 1'b0;
    w_stuck_clr   = 1'b0;

    if (bus.clear) begin
      w_mon_next = IDLE;
    end else begin
      case (r_mon_state)
        IDLE: begin
          if (bus.state_valid) begin
            w_upd_prev    = 1'b1;
            w_upd_visited = 1'b1;
            if (w_illegal) begin
              w_mon_next    = ERROR;
              w_set_illegal = 1'b1;
            end else begin
              w_mon_next = TRACK;
            end
          end
        end
        TRACK: begin
          if (bus.state_valid) begin
            w_upd_visited = 1'b1;
            if (w_illegal) begin
              w_mon_next    = ERROR;
              w_set_illegal = 1'b1;
            end else if (bus.state_in != r_prev_state) begin
              w_upd_prev  = 1'b1;
              w_trans_inc = 1'b1;
              w_stuck_clr = 1'b1;
            end else begin
              w_stuck_inc = 1'b1;
            end
          end
        end
        ERROR: begin
          w_mon_next = ERROR;
        end
        // Unused encoding falls into ERROR rather than locking up.
        default: begin
          w_mon_next = ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mon_state <= IDLE;
    end else begin
      r_mon_state <= w_mon_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_state     <= '0;
      r_visited        <= '0;
      r_illegal_pulse  <= 1'b0;
      r_illegal_sticky <= 1'b0;
      r_stuck          <= 1'b0;
    end else if (bus.clear) begin
      r_prev_state     <= '0;
      r_visited        <= '0;
      r_illegal_pulse  <= 1'b0;
      r_illegal_sticky <= 1'b0;
      r_stuck          <= 1'b0;
    end else begin
      r_illegal_pulse <= w_set_illegal;
      if (w_set_illegal) r_illegal_sticky <= 1'b1;
      if (w_upd_prev) r_prev_state <= bus.state_in;
      if (w_upd_visited) r_visited[bus.state_in] <= 1'b1;
      // stuck follows the value the counter takes at this edge
      if (w_stuck_clr) begin
        r_stuck <= 1'b0;
      end else if (w_stuck_inc) begin
        r_stuck <= (w_stuck_cnt >= SC_W'(STUCK_LIMIT - 1));
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_trans_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .inc   (w_trans_inc),
    .count (w_trans_cnt)
  );

  sat_counter #(
    .WIDTH (SC_W),
    .MAX   (SC_W'(STUCK_LIMIT))
  ) u_stuck_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear | w_stuck_clr),
    .inc   (w_stuck_inc),
    .count (w_stuck_cnt)
  );

  assign bus.visited        = r_visited;
  assign bus.trans_count    = w_trans_cnt;
  assign bus.illegal_pulse  = r_illegal_pulse;
  assign bus.illegal_sticky = r_illegal_sticky;
  assign bus.stuck          = r_stuck;
  assign bus.all_visited    = &r_visited[NUM_STATES-1:0];
  assign bus.mon_state      = r_mon_state;

endmodule : fsm_state_monitor

// File: tb/tb_fsm_state_monitor.sv
// ---------------------------------------------------------------------------
// tb_fsm_state_monitor
// Directed and random stimulus against a behavioural model of the monitor.
// ---------------------------------------------------------------------------
module tb_fsm_state_monitor;
  import fsm_mon_pkg::*;

  localparam int SW   = 2;
  localparam int NS   = 3;
  localparam int SL   = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fsm_state_monitor_if #(.STATE_W(SW), .CNT_W(CW)) bus ();

  fsm_state_monitor #(
    .STATE_W     (SW),
    .NUM_STATES  (NS),
    .STUCK_LIMIT (SL),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // model: phase 0 = nothing seen, 1 = tracking legal samples, 2 = illegal seen
  int        m_phase;
  bit [3:0]  m_vis;
  int        m_tc;
  int        m_run;
  int        m_prev;
  bit        m_pulse;
  bit        m_sticky;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_vis = '0; m_tc = 0; m_run = 0; m_prev = 0;
    m_pulse = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit v, input int st, input bit c);
    bit ill;
    m_pulse = 0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v || m_phase == 2) return;
    ill = (st >= NS);
    m_vis[st] = 1'b1;
    if (m_phase == 0) begin
      m_prev = st;
      m_run  = 0;
      if (ill) begin m_phase = 2; m_pulse = 1; m_sticky = 1; end
      else m_phase = 1;
    end else begin
      if (ill) begin
        m_phase = 2; m_pulse = 1; m_sticky = 1;
      end else if (st != m_prev) begin
        m_tc   = (m_tc < CMAX) ? m_tc + 1 : CMAX;
        m_run  = 0;
        m_prev = st;
      end else begin
        m_run = (m_run < SL) ? m_run + 1 : SL;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] em;
    em = (m_phase == 0) ? IDLE : (m_phase == 1) ? TRACK : ERROR;
    chk({tag, "_vis"},    32'(bus.visited),        32'(m_vis));
    chk({tag, "_tc"},     32'(bus.trans_count),    32'(m_tc));
    chk({tag, "_pulse"},  32'(bus.illegal_pulse),  32'(m_pulse));
    chk({tag, "_sticky"}, 32'(bus.illegal_sticky), 32'(m_sticky));
    chk({tag, "_stuck"},  32'(bus.stuck),          32'(m_run >= SL));
    chk({tag, "_allv"},   32'(bus.all_visited),    32'(&m_vis[NS-1:0]));
    chk({tag, "_mon"},    32'(bus.mon_state),      32'(em));
  endtask

  task automatic step(input string tag, input bit v, input int st, input bit c);
    @(negedge clk);
    bus.state_valid = v;
    bus.state_in    = SW'(st);
    bus.clear       = c;
    @(posedge clk);
    model_step(v, st, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    int st;
    int last;
    bit v;
    bit c;

    rst             = 1'b1;
    bus.state_valid = 1'b0;
    bus.state_in    = '0;
    bus.clear       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset");

    // three legal states in a row
    step("seq0", 1, 0, 0);
    step("seq1", 1, 1, 0);
    step("seq2", 1, 2, 0);
    chk("tp1_vis",  32'(bus.visited),     32'h7);
    chk("tp1_tc",   32'(bus.trans_count), 32'd2);
    chk("tp1_allv", 32'(bus.all_visited), 32'd1);
    chk("tp1_mon",  32'(bus.mon_state),   32'(TRACK));

    // stuck detection: enter state 1, then 16 repeats
    step("stk_enter", 1, 1, 0);
    for (int i = 1; i <= SL; i++) begin
      step("stk_rep", 1, 1, 0);
      if (i == SL - 1) chk("stk_15th", 32'(bus.stuck), 32'd0);
      if (i == SL)     chk("stk_16th", 32'(bus.stuck), 32'd1);
    end
    step("stk_idle", 0, 1, 0);
    chk("stk_hold", 32'(bus.stuck), 32'd1);
    step("stk_leave", 1, 2, 0);
    chk("stk_leave_stuck", 32'(bus.stuck), 32'd0);
    chk("stk_leave_tc", 32'(bus.trans_count), 32'd4);

    // clear together with a valid sample: sample discarded
    step("clrv", 1, 2, 1);
    chk("clrv_vis", 32'(bus.visited),   32'd0);
    chk("clrv_mon", 32'(bus.mon_state), 32'(IDLE));

    // saturation of the transition counter
    for (int i = 0; i < 300; i++) step("sat", 1, i % 2, 0);
    chk("sat_tc", 32'(bus.trans_count), 32'd255);

    // illegal encoding
    step("ill_clr", 0, 0, 1);
    step("ill_0", 1, 0, 0);
    step("ill_3", 1, 3, 0);
    chk("ill_pulse",  32'(bus.illegal_pulse),  32'd1);
    chk("ill_sticky", 32'(bus.illegal_sticky), 32'd1);
    chk("ill_v3",     32'(bus.visited[3]),     32'd1);
    chk("ill_mon",    32'(bus.mon_state),      32'(ERROR));
    step("ill_f1", 1, 1, 0);
    chk("ill_pulse_end", 32'(bus.illegal_pulse), 32'd0);
    step("ill_f2", 1, 2, 0);
    step("ill_f3", 1, 3, 0);
    chk("ill_frozen_vis", 32'(bus.visited),     32'h9);
    chk("ill_frozen_tc",  32'(bus.trans_count), 32'd0);

    // illegal as first sample after clear
    step("ill_first_clr", 0, 0, 1);
    step("ill_first", 1, 3, 0);

    // asynchronous reset between edges
    step("ar_clr", 0, 0, 1);
    step("ar_0", 1, 0, 0);
    step("ar_1", 1, 1, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    bus.state_valid = 1'b0;
    #2;
    rst = 1'b0;
    step("ar_resume", 1, 2, 0);
    chk("ar_resume_mon", 32'(bus.mon_state), 32'(TRACK));
    chk("ar_resume_tc",  32'(bus.trans_count), 32'd0);

    // random stream with biased repeats, rare illegal samples and clears
    last = 0;
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) st = 3;
      else if ($urandom_range(0, 2) == 0) st = $urandom_range(0, NS - 1);
      else st = last;
      if (st < NS) last = st;
      step("rnd", v, st, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fsm_state_monitor
